fstore_dump: RTL and testbench
==============================

Name: fstore_dump

Overview:
- Reader for the character frame store that the keyboard path writes through port B.
- On a start pulse, scans the 8 KiB text buffer row by row and streams the screen contents as a byte stream over a valid/ready interface, e.g. to a UART transmitter for screen capture.
- Trailing spaces on each row are suppressed; each row ends with CR LF (0x0D 0x0A).
- Owns port B only while busy; external logic muxes addrb/enb/web on `busy`.

Parameters:
- COLS, 128, characters per row; power of two, ≤256.
- ROWS, 64, rows scanned.
- ADDR_W, 13, frame-store address width; must equal log2(COLS)+log2(ROWS).
- RD_LAT, 1, frame-store read latency in cycles (1 or 2).

Ports:
- clk_p  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse to begin a dump; ignored while busy
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse after the final LF handshake
- addrb  out  ADDR_W  frame-store address, {row, col}
- enb  out  1  frame-store enable
- web  out  1  frame-store write enable; constant 0
- doutb  in  8  frame-store read data
- tx_data  out  8  output byte
- tx_valid  out  1  output byte valid
- tx_ready  in  1  sink accepts byte when valid&&ready

Behaviour:
- Reset values: busy=0, done=0, addrb=0, enb=0, web=0, tx_data=0, tx_valid=0; FSM enters IDLE, and row, col and pend counters clear. Reset mid-dump aborts immediately with no further bytes; a byte held on tx_data is dropped.
- Character classification: ch=doutb[6:0] (bit 7 ignored). If ch<0x20 or ch==0x7F, treat as space (0x20).
- States:
  - IDLE: start → READ with row=0, col=0, pend=0, busy=1.
  - READ: drive addrb={row,col}, enb=1 for one cycle → WAIT.
  - WAIT: RD_LAT cycles → EVAL. enb drops after READ.
  - EVAL, char is space: pend++. Then next column, or EOL if col==COLS-1.
  - EVAL, char non-space: go to EMIT_SP if pend>0, else EMIT_CH.
  - EMIT_SP: tx_data=0x20, tx_valid=1. Each handshake decrements pend; when pend reaches 0 → EMIT_CH.
  - EMIT_CH: tx_data=ch, tx_valid=1. On handshake, go to next column or, if col==COLS-1, EOL.
  - Next column: col++, → READ.
  - EOL: pend cleared (trailing spaces discarded) → EMIT_CR → (handshake) EMIT_LF → (handshake). If row==ROWS-1 → DONE; else row++, col=0 → READ.
  - DONE: done=1 for one cycle, busy=0 → IDLE.
- Handshake rules:
  - While tx_valid=1 and tx_ready=0, tx_data and tx_valid hold stable.
  - tx_valid never drops without a handshake, except on rst.
  - Back-to-back bytes are allowed: one byte per cycle for pend spaces.
- Widths: pend is log2(COLS)+1 bits and cannot exceed COLS-1 when emitted. col and row wrap only via the explicit transitions.
- Throughput: minimum per character is 2+RD_LAT cycles, with no pipelining of reads; the simplicity is intentional.
- Boundary cases:
  - Blank row emits only CR LF.
  - Full row of non-spaces emits COLS bytes plus CR LF.
  - A non-space in the last column flushes pending spaces before it.
  - start coinciding with done cycle is ignored; start is sampled in IDLE only.

Decomposition:
- Shared package fstore_pkg:
  - constants COLS, ROWS, FS_ADDR_W=13, CH_SPACE=8'h20, CH_CR=8'h0D, CH_LF=8'h0A;
  - state enum for this FSM.
- No sub-module is needed: one FSM with row/col/pend counters and a registered output stage. The printable-classification function lives in fstore_pkg for reuse by the writer side.

Test Plan:
- All-space buffer, start pulse, tx_ready=1 → exactly 128 bytes alternating 0x0D,0x0A; done pulses once; busy low afterwards.
- Row 0 = "AB" at cols 0,1, rest spaces → 0x41,0x42,0x0D,0x0A followed by 63 CR LF pairs.
- Row 5 = 'A' at col 0 and 'B' at col 3 → within row 5: 0x41,0x20,0x20,0x42,0x0D,0x0A.
- tx_ready held low 5 cycles during the 'B' of the previous scenario → tx_data=0x42 and tx_valid stay stable; no byte lost or duplicated.
- Control and high-bit characters:
  - Byte 0x0A stored at row 0 col 0 with 'Z' at col 1 → 0x20,0x5A.
  - 0xC1 at col 0 → emitted as 0x41.
- Abort and re-start:
  - rst asserted mid-row 10 → next cycle tx_valid=0, busy=0, enb=0.
  - Fresh start afterwards → dump begins at addrb=0.
  - start pulsed while busy → ignored; byte count unchanged.

Source files
------------

// File: rtl/fstore_pkg.sv
// Shared definitions for the character frame store: geometry, control bytes,
// the dump FSM state encoding and the printable-character classifier.
package fstore_pkg;

  localparam int COLS      = 128;
  localparam int ROWS      = 64;
  localparam int FS_ADDR_W = 13;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_READ    = 4'd1,
    S_WAIT    = 4'd2,
    S_EVAL    = 4'd3,
    S_EMIT_SP = 4'd4,
    S_EMIT_CH = 4'd5,
    S_EOL     = 4'd6,
    S_EMIT_CR = 4'd7,
    S_EMIT_LF = 4'd8,
    S_DONE    = 4'd9
  } fs_state_t;

  // Bit 7 is ignored; control codes and DEL read back as a blank cell.
  function automatic logic [7:0] fs_printable(input logic [7:0] b);
    logic [6:0] ch;
    ch = b[6:0];
    if (ch < 7'h20 || ch == 7'h7F) return CH_SPACE;
    return {1'b0, ch};
  endfunction

endpackage

// File: rtl/fstore_dump.sv
// Scans the text frame store through port B and streams it row by row as bytes,
// dropping trailing blanks and terminating every row with CR LF.
module fstore_dump #(
  parameter int COLS   = fstore_pkg::COLS,
  parameter int ROWS   = fstore_pkg::ROWS,
  parameter int ADDR_W = fstore_pkg::FS_ADDR_W,
  parameter int RD_LAT = 1
) (
  input  logic                  clk_p,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     addrb,
  output logic                  enb,
  output logic                  web,
  input  logic [7:0]            doutb,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output fstore_pkg::fs_state_t o_dbg_state
);
  import fstore_pkg::*;

  localparam int COL_W  = $clog2(COLS);
  localparam int ROW_W  = $clog2(ROWS);
  localparam int PEND_W = COL_W + 1;
  localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

  fs_state_t          r_state;
  fs_state_t          w_next;
  logic [ROW_W-1:0]   r_row;
  logic [COL_W-1:0]   r_col;
  logic [PEND_W-1:0]  r_pend;
  logic [7:0]         r_ch;
  logic [1:0]         r_wait;

  logic w_hs;
  logic w_last_col;
  logic w_last_row;
  logic w_is_space;

  // Byte transfer: a byte moves on every rising edge where tx_valid && tx_ready;
  // once tx_valid rises, tx_valid/tx_data hold until that transfer (or rst).
  assign w_hs       = tx_valid && tx_ready;
  assign w_last_col = (r_col == COL_W'(COLS - 1));
  assign w_last_row = (r_row == ROW_W'(ROWS - 1));
  assign w_is_space = (r_ch == CH_SPACE);

  always_ff @(posedge clk_p) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = S_READ;
      S_READ:    w_next = S_WAIT;
      S_WAIT:    if (r_wait == WAIT_LAST) w_next = S_EVAL;
      S_EVAL: begin
        if (w_is_space)            w_next = w_last_col ? S_EOL : S_READ;
        else if (r_pend != '0)     w_next = S_EMIT_SP;
        else                       w_next = S_EMIT_CH;
      end
      S_EMIT_SP: if (w_hs && r_pend == PEND_W'(1)) w_next = S_EMIT_CH;
      S_EMIT_CH: if (w_hs) w_next = w_last_col ? S_EOL : S_READ;
      S_EOL:     w_next = S_EMIT_CR;
      S_EMIT_CR: if (w_hs) w_next = S_EMIT_LF;
      S_EMIT_LF: if (w_hs) w_next = w_last_row ? S_DONE : S_READ;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Counters and the captured character; pend counts blanks not yet known to be interior.
  always_ff @(posedge clk_p) begin
    if (rst) begin
      r_row  <= '0;
      r_col  <= '0;
      r_pend <= '0;
      r_ch   <= '0;
      r_wait <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_row  <= '0;
          r_col  <= '0;
          r_pend <= '0;
        end
        S_READ: r_wait <= '0;
        S_WAIT: begin
          r_wait <= r_wait + 2'd1;
          if (r_wait == WAIT_LAST) r_ch <= fs_printable(doutb);
        end
        S_EVAL: if (w_is_space) begin
          r_pend <= r_pend + PEND_W'(1);
          if (!w_last_col) r_col <= r_col + COL_W'(1);
        end
        S_EMIT_SP: if (w_hs) r_pend <= r_pend - PEND_W'(1);
        S_EMIT_CH: if (w_hs && !w_last_col) r_col <= r_col + COL_W'(1);
        S_EOL:     r_pend <= '0;
        S_EMIT_LF: if (w_hs && !w_last_row) begin
          r_row <= r_row + ROW_W'(1);
          r_col <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy     = (r_state != S_IDLE) && (r_state != S_DONE);
    done     = (r_state == S_DONE);
    enb      = (r_state == S_READ);
    web      = 1'b0;
    addrb    = '0;
    tx_valid = 1'b0;
    tx_data  = '0;
    if (r_state == S_READ) addrb = {r_row, r_col};
    case (r_state)
      S_EMIT_SP: begin tx_valid = 1'b1; tx_data = CH_SPACE; end
      S_EMIT_CH: begin tx_valid = 1'b1; tx_data = r_ch;     end
      S_EMIT_CR: begin tx_valid = 1'b1; tx_data = CH_CR;    end
      S_EMIT_LF: begin tx_valid = 1'b1; tx_data = CH_LF;    end
      default: ;
    endcase
  end

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fstore_dump.sv
// Scoreboard bench for fstore_dump with a 32x64 frame store model.
module tb_fstore_dump;
  import fstore_pkg::*;

  localparam int TB_COLS = 32;
  localparam int TB_ROWS = 64;
  localparam int TB_AW   = 11;

  logic              clk_p = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              busy, done, enb, web, tx_valid;
  logic              tx_ready = 1'b1;
  logic [TB_AW-1:0]  addrb;
  logic [7:0]        doutb = 8'h00;
  logic [7:0]        tx_data;
  fs_state_t         dbg_state;

  logic [7:0] mem [0:(1<<TB_AW)-1];
  logic [7:0] exp_q[$];

  int n_tests = 0;
  int n_fail = 0;
  int nbytes = 0;
  int done_cnt = 0;
  int stall_left = 0;
  int stall_seen = 0;
  int ready_mode = 0;
  logic       stall_prev = 1'b0;
  logic [7:0] prev_data = 8'h00;

  fstore_dump #(.COLS(TB_COLS), .ROWS(TB_ROWS), .ADDR_W(TB_AW), .RD_LAT(1)) dut (
    .clk_p(clk_p), .rst(rst), .start(start), .busy(busy), .done(done),
    .addrb(addrb), .enb(enb), .web(web), .doutb(doutb),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .o_dbg_state(dbg_state)
  );

  // clock / frame store model
  always #5 clk_p = ~clk_p;
  always @(posedge clk_p) if (enb) doutb <= mem[addrb];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // sink: decides tx_ready, checks hold stability, pops the scoreboard on each transfer
  always @(negedge clk_p) begin
    if (rst) begin
      stall_prev = 1'b0;
      tx_ready   = 1'b1;
    end else begin
      case (ready_mode)
        1: begin
          if (tx_valid && tx_data == 8'h42 && stall_left > 0) begin
            tx_ready = 1'b0;
            stall_left--;
            stall_seen++;
          end else tx_ready = 1'b1;
        end
        2:       tx_ready = ~tx_ready;
        default: tx_ready = 1'b1;
      endcase
      if (stall_prev) begin
        check("hold_valid", {31'd0, tx_valid}, 32'd1);
        check("hold_data", {24'd0, tx_data}, {24'd0, prev_data});
      end
      if (tx_valid && tx_ready) begin
        nbytes++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL extra_byte: got 0x%0h expected no byte", tx_data);
        end else begin
          check("byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
        end
      end
      stall_prev = tx_valid && !tx_ready;
      prev_data  = tx_data;
      if (done) done_cnt++;
    end
  end

  // driver tasks
  task automatic clear_mem();
    for (int i = 0; i < (1 << TB_AW); i++) mem[i] = 8'h20;
  endtask

  task automatic set_ch(input int row, input int col, input logic [7:0] v);
    mem[row * TB_COLS + col] = v;
  endtask

  task automatic push_crlf(input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endtask

  task automatic push_n(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(b);
  endtask

  task automatic reset_counts();
    nbytes   = 0;
    done_cnt = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk_p);
    start = 1'b1;
    @(negedge clk_p);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit poke);
    int c;
    c = 0;
    while (!done && c < budget) begin
      @(negedge clk_p);
      c++;
    end
    if (!done) check("done_timeout", {31'd0, done}, 32'd1);
    else if (poke) begin
      start = 1'b1;
      @(negedge clk_p);
      start = 1'b0;
    end
  endtask

  task automatic end_checks(input string tag, input int exp_bytes);
    repeat (5) @(negedge clk_p);
    check({tag, "_bytes"}, nbytes, exp_bytes);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
    check({tag, "_q_left"}, exp_q.size(), 0);
  endtask

  task automatic push_hello_dump();
    push_crlf(10);
    exp_q.push_back(8'h48); exp_q.push_back(8'h45); exp_q.push_back(8'h4C);
    exp_q.push_back(8'h4C); exp_q.push_back(8'h4F);
    push_crlf(54);
  endtask

  initial begin
    int c;
    clear_mem();
    rst = 1'b1;
    repeat (3) @(negedge clk_p);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_addrb", {21'd0, addrb}, 32'd0);
    check("rst_enb", {31'd0, enb}, 32'd0);
    check("rst_web", {31'd0, web}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_state", {28'd0, dbg_state}, {28'd0, S_IDLE});
    rst = 1'b0;

    // all blank; start held during the done cycle must not relaunch
    ready_mode = 0;
    push_crlf(64);
    reset_counts();
    pulse_start();
    wait_done(10000, 1'b1);
    end_checks("blank", 128);
    check("blank_state_idle", {28'd0, dbg_state}, {28'd0, S_IDLE});

    // "AB" on row 0, "A  B" on row 5 with a 5-cycle stall on the second B
    clear_mem();
    set_ch(0, 0, 8'h41); set_ch(0, 1, 8'h42);
    set_ch(5, 0, 8'h41); set_ch(5, 3, 8'h42);
    exp_q.push_back(8'h41); exp_q.push_back(8'h42); push_crlf(1);
    push_crlf(4);
    exp_q.push_back(8'h41); push_n(8'h20, 2); exp_q.push_back(8'h42); push_crlf(1);
    push_crlf(58);
    ready_mode = 1;
    stall_left = 0;
    stall_seen = 0;
    reset_counts();
    pulse_start();
    c = 0;
    while (!(enb && addrb[10:5] == 6'd5) && c < 2000) begin
      @(negedge clk_p);
      c++;
    end
    check("row5_reached", {31'd0, enb}, 32'd1);
    stall_left = 5;
    wait_done(10000, 1'b0);
    end_checks("ab", 134);
    check("stall_cycles", stall_seen, 5);

    // control codes, high bit, DEL, full row, last-column flush; alternating ready
    clear_mem();
    set_ch(0, 0, 8'h0A); set_ch(0, 1, 8'h5A);
    set_ch(1, 0, 8'hC1);
    for (int i = 0; i < TB_COLS; i++) set_ch(2, i, 8'h58);
    set_ch(3, TB_COLS - 1, 8'h51);
    set_ch(4, 0, 8'h7F); set_ch(4, 1, 8'h79);
    exp_q.push_back(8'h20); exp_q.push_back(8'h5A); push_crlf(1);
    exp_q.push_back(8'h41); push_crlf(1);
    push_n(8'h58, 32); push_crlf(1);
    push_n(8'h20, 31); exp_q.push_back(8'h51); push_crlf(1);
    exp_q.push_back(8'h20); exp_q.push_back(8'h79); push_crlf(1);
    push_crlf(59);
    ready_mode = 2;
    reset_counts();
    pulse_start();
    wait_done(20000, 1'b0);
    end_checks("ctrl", 197);

    // abort mid row 10
    clear_mem();
    set_ch(10, 0, 8'h48); set_ch(10, 1, 8'h45); set_ch(10, 2, 8'h4C);
    set_ch(10, 3, 8'h4C); set_ch(10, 4, 8'h4F);
    push_hello_dump();
    ready_mode = 0;
    reset_counts();
    pulse_start();
    c = 0;
    while (!(tx_valid && tx_data == 8'h4C) && c < 5000) begin
      @(negedge clk_p);
      c++;
    end
    check("abort_reach_L", {24'd0, tx_data}, 32'h4C);
    rst = 1'b1;
    @(negedge clk_p);
    check("abort_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_enb", {31'd0, enb}, 32'd0);
    check("abort_tx_data", {24'd0, tx_data}, 32'd0);
    rst = 1'b0;
    exp_q.delete();

    // fresh start from address 0, with a start pulse while busy
    push_hello_dump();
    reset_counts();
    pulse_start();
    check("restart_busy", {31'd0, busy}, 32'd1);
    c = 0;
    while (!enb && c < 20) begin
      @(negedge clk_p);
      c++;
    end
    check("restart_enb", {31'd0, enb}, 32'd1);
    check("restart_addr0", {21'd0, addrb}, 32'd0);
    repeat (20) @(negedge clk_p);
    start = 1'b1;
    @(negedge clk_p);
    start = 1'b0;
    wait_done(10000, 1'b0);
    end_checks("restart", 133);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
